sd_spi_ctrl: RTL and testbench

SD_SPI_CTRL -- requirements
Module: sd_spi_ctrl

---
 rtl/sd_spi_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_sd_spi_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_ctrl.sv
// Single-block SD card SPI-mode controller: CMD17 block read / CMD24 block write of a 64-bit payload.
// Define SD_CRC16_CHECK_EN to flag a read whose received CRC16 disagrees with the computed one.
module sd_spi_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_write,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [63:0]       in_data,
    output logic              ready,
    output logic              MOSI,
    input  logic              MISO,
    output logic              out_valid,
    output logic [63:0]       out_data,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_WAIT_R1, S_R1, S_GAP, S_TX, S_WAIT_DRESP,
        S_DRESP, S_BUSY, S_WAIT_TOKEN, S_RX, S_DONE
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    logic        wr;
    logic [6:0]  cnt;
    logic [31:0] wcnt;
    logic [39:0] cmdsh;
    logic [63:0] dsh;
    logic [63:0] rd;
    logic [6:0]  crc7;
    logic [15:0] crc16;
    logic [6:0]  rsh;
`ifdef SD_CRC16_CHECK_EN
    logic [14:0] rxcrc;
`endif

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            MOSI      <= 1'b1;
            out_valid <= 1'b0;
            err       <= 1'b0;
            out_data  <= '0;
            wr        <= 1'b0;
            cnt       <= '0;
            wcnt      <= '0;
            cmdsh     <= '0;
            dsh       <= '0;
            rd        <= '0;
            crc7      <= '0;
            crc16     <= '0;
            rsh       <= '0;
`ifdef SD_CRC16_CHECK_EN
            rxcrc     <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (in_valid) begin
                    // Frame bit 0 ('0') goes out now; cmdsh holds frame bits 1..39.
                    wr    <= in_write;
                    cmdsh <= {1'b1, (in_write ? 6'd24 : 6'd17), 32'(in_addr), 1'b0};
                    dsh   <= in_data;
                    crc7  <= '0;
                    crc16 <= '0;
                    cnt   <= 7'd1;
                    MOSI  <= 1'b0;
                    ready <= 1'b0;
                    state <= S_CMD;
                end
                S_CMD: begin
                    if (cnt < 7'd40) begin
                        MOSI  <= cmdsh[39];
                        crc7  <= crc7_step(crc7, cmdsh[39]);
                        cmdsh <= {cmdsh[38:0], 1'b0};
                    end else if (cnt < 7'd47) begin
                        MOSI <= crc7[6];
                        crc7 <= {crc7[5:0], 1'b0};
                    end else begin
                        MOSI <= 1'b1;
                    end
                    if (cnt == 7'd48) begin
                        state <= S_WAIT_R1;
                        wcnt  <= '0;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_WAIT_R1, S_WAIT_DRESP: begin
                    if (!MISO) begin
                        rsh   <= '0;
                        cnt   <= 7'd1;
                        state <= (state == S_WAIT_R1) ? S_R1 : S_DRESP;
                    end else if (wcnt == TO_LAST) begin
                        err <= 1'b1; out_valid <= 1'b1; state <= S_DONE;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                end
                S_R1: begin
                    if (cnt == 7'd7) begin
                        if ({rsh, MISO} != 8'h00) begin
                            err <= 1'b1; out_valid <= 1'b1; state <= S_DONE;
                        end else if (wr) begin
                            cnt <= '0; state <= S_GAP;
                        end else begin
                            wcnt <= '0; state <= S_WAIT_TOKEN;
                        end
                    end else begin
                        rsh <= {rsh[5:0], MISO};
                        cnt <= cnt + 7'd1;
                    end
                end
                S_GAP: begin
                    MOSI <= 1'b1;
                    if (cnt == 7'd7) begin
                        cnt <= 7'd1; state <= S_TX;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_TX: begin
                    // Token MSB was emitted on GAP exit; cnt indexes the bit being launched.
                    if (cnt < 7'd8) begin
                        MOSI <= (cnt != 7'd7);
                    end else if (cnt < 7'd72) begin
                        MOSI  <= dsh[63];
                        crc16 <= crc16_step(crc16, dsh[63]);
                        dsh   <= {dsh[62:0], 1'b0};
                    end else if (cnt < 7'd88) begin
                        MOSI  <= crc16[15];
                        crc16 <= {crc16[14:0], 1'b0};
                    end
                    if (cnt == 7'd88) begin
                        MOSI <= 1'b1; wcnt <= '0; state <= S_WAIT_DRESP;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_DRESP: begin
                    if (cnt == 7'd7) begin
                        if ({rsh, MISO} == 8'h05) begin
                            wcnt <= '0; state <= S_BUSY;
                        end else begin
                            err <= 1'b1; out_valid <= 1'b1; state <= S_DONE;
                        end
                    end else begin
                        rsh <= {rsh[5:0], MISO};
                        cnt <= cnt + 7'd1;
                    end
                end
                S_BUSY: begin
                    if (MISO) begin
                        err <= 1'b0; out_valid <= 1'b1; state <= S_DONE;
                    end else if (wcnt == TO_LAST) begin
                        err <= 1'b1; out_valid <= 1'b1; state <= S_DONE;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                end
                S_WAIT_TOKEN: begin
                    if (!MISO) begin
                        cnt <= '0; crc16 <= '0; state <= S_RX;
                    end else if (wcnt == TO_LAST) begin
                        err <= 1'b1; out_valid <= 1'b1; state <= S_DONE;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                end
                S_RX: begin
                    if (cnt < 7'd64) begin
                        rd    <= {rd[62:0], MISO};
                        crc16 <= crc16_step(crc16, MISO);
                    end
`ifdef SD_CRC16_CHECK_EN
                    else begin
                        rxcrc <= {rxcrc[13:0], MISO};
                    end
`endif
                    if (cnt == 7'd79) begin
                        out_data  <= rd;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`ifdef SD_CRC16_CHECK_EN
                        err <= ({rxcrc, MISO} != crc16);
`else
                        err <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Self-checking bench for sd_spi_ctrl: a card model drives MISO from a bit schedule and a
// reference model predicts the MOSI stream, completion cycle, err and out_data.
module tb_sd_spi_ctrl;
    localparam int TIMEOUT = 1024;
    localparam int ADDR_W  = 16;
`ifdef SD_CRC16_CHECK_EN
    localparam bit CRC_CHK = 1'b1;
`else
    localparam bit CRC_CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_write;
    logic [ADDR_W-1:0] in_addr;
    logic [63:0]       in_data;
    logic              ready, MOSI, MISO, out_valid, err;
    logic [63:0]       out_data;

    always #5 clk = ~clk;

    sd_spi_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_write(in_write),
        .in_addr(in_addr), .in_data(in_data), .ready(ready), .MOSI(MOSI),
        .MISO(MISO), .out_valid(out_valid), .out_data(out_data), .err(err)
    );

    int          n_cmp = 0, n_bad = 0;
    bit          miso_q[$];
    bit          mosi_q[$];
    int          done_t;
    logic        cap_err, ready_t0, post_ready, post_valid;
    logic        ab_mosi, ab_ready, ab_valid;
    logic [63:0] cap_data;
    logic [63:0] last_out = '0;
    logic [63:0] mem [int];

    // CRCs as remainders of polynomial division (x^7+x^3+1, x^16+x^12+x^5+1).
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) if (r[i]) r[i-:8] ^= 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [15:0] crc16_ref(input logic [63:0] d);
        logic [79:0] r = {d, 16'b0};
        for (int i = 79; i >= 16; i--) if (r[i]) r[i-:17] ^= 17'h11021;
        return r[15:0];
    endfunction

    function automatic int exp_done(input bit wr, input int g, input int h, input int b,
                                    input int idle, input logic [7:0] r1, input logic [7:0] dr);
        if (r1 != 8'h00) return 56 + g;
        if (wr) return (dr == 8'h05) ? 161 + g + h + b : 160 + g + h;
        return 144 + g + 8 * idle;
    endfunction

    // Number of MOSI samples 0..upto that differ from the expected line.
    function automatic int mosi_errs(input bit wr, input logic [15:0] a, input logic [63:0] d,
                                     input int g, input bit txexp, input int upto);
        logic [39:0] m  = {2'b01, (wr ? 6'd24 : 6'd17), 16'h0000, a};
        logic [47:0] f  = {m, crc7_ref(m), 1'b1};
        logic [87:0] tx = {8'hFE, d, crc16_ref(d)};
        bit e;
        int n = 0;
        for (int t = 0; t <= upto && t < mosi_q.size(); t++) begin
            if (t < 48) e = f[47-t];
            else if (txexp && t >= 64 + g && t < 152 + g) e = tx[87-(t-64-g)];
            else e = 1'b1;
            if (mosi_q[t] !== e) n++;
        end
        if (upto >= mosi_q.size()) n++;
        return n;
    endfunction

    function automatic logic [63:0] decode_wdata(input int g);
        logic [63:0] d = '0;
        for (int k = 0; k < 64; k++)
            if (72 + g + k < mosi_q.size()) d[63-k] = mosi_q[72+g+k];
        return d;
    endfunction

    task automatic build_stream(input bit wr, input logic [63:0] d, input int g, input int h,
                                input int b, input int idle, input logic [7:0] r1,
                                input logic [7:0] dr, input int flip);
        logic [7:0]  tk = 8'hFE;
        logic [15:0] c  = crc16_ref(d);
        if (flip >= 0) c[flip] = ~c[flip];
        miso_q.delete();
        repeat (48 + g) miso_q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) miso_q.push_back(r1[i]);
        if (r1 == 8'h00) begin
            if (wr) begin
                repeat (96 + h) miso_q.push_back(1'b1);
                for (int i = 7; i >= 0; i--) miso_q.push_back(dr[i]);
                repeat (b) miso_q.push_back(1'b0);
            end else begin
                repeat (8 * idle) miso_q.push_back(1'b1);
                for (int i = 7; i >= 0; i--) miso_q.push_back(tk[i]);
                for (int i = 63; i >= 0; i--) miso_q.push_back(d[i]);
                for (int i = 15; i >= 0; i--) miso_q.push_back(c[i]);
            end
        end
    endtask

    // Issues one request, then plays miso_q one bit per cycle; inputs toggle randomly while busy.
    task automatic run_txn(input bit wr, input logic [15:0] a, input logic [63:0] d,
                           input int limit, input int abort_at);
        in_valid = 1'b1; in_write = wr; in_addr = a; in_data = d; MISO = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ready_t0 = ready;
        mosi_q.delete();
        done_t = -1;
        for (int t = 0; t < limit; t++) begin
            mosi_q.push_back(MOSI);
            if (out_valid) begin
                done_t = t; cap_err = err; cap_data = out_data;
                break;
            end
            if (t == abort_at) begin
                in_valid = 1'b0; rst_n = 1'b0; #1;
                ab_mosi = MOSI; ab_ready = ready; ab_valid = out_valid;
                break;
            end
            MISO     = (t < miso_q.size()) ? miso_q[t] : 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            in_write = 1'($urandom_range(0, 1));
            in_addr  = 16'($urandom);
            in_data  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0; MISO = 1'b1;
        if (done_t >= 0) begin
            @(posedge clk); #1;
            post_ready = ready; post_valid = out_valid;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; in_valid = 1'b0; in_write = 1'b0; in_addr = '0; in_data = '0; MISO = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (MOSI !== 1'b1) begin n_bad++; $display("FAIL reset_mosi: got %b want 1", MOSI); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1 || MOSI !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_idle: got ready=%b mosi=%b want 1 1", ready, MOSI);
        end
    endtask

    task automatic test_write_basic;
        logic [63:0] d = 64'h0123456789ABCDEF;
        int ed = exp_done(1'b1, 8, 3, 5, 0, 8'h00, 8'h05);
        int nm;
        build_stream(1'b1, '0, 8, 3, 5, 0, 8'h00, 8'h05, -1);
        run_txn(1'b1, 16'h0010, d, ed + 40, -1);
        nm = mosi_errs(1'b1, 16'h0010, d, 8, 1'b1, done_t);
        n_cmp++; if (ready_t0 !== 1'b0) begin n_bad++; $display("FAIL wr_busy_ready: got %b want 0", ready_t0); end
        n_cmp++; if (done_t !== ed) begin n_bad++; $display("FAIL wr_done_cycle: got %0d want %0d", done_t, ed); end
        n_cmp++; if (cap_err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", cap_err); end
        n_cmp++; if (nm !== 0) begin n_bad++; $display("FAIL wr_mosi: got %0d bad bits want 0", nm); end
        n_cmp++; if (post_ready !== 1'b1 || post_valid !== 1'b0) begin
            n_bad++; $display("FAIL wr_after_done: got ready=%b valid=%b want 1 0", post_ready, post_valid);
        end
        mem[16'h0010] = decode_wdata(8);
    endtask

    task automatic test_read_basic;
        logic [63:0] card = mem.exists(16'h0010) ? mem[16'h0010] : 64'h0;
        int ed = exp_done(1'b0, 2, 0, 0, 3, 8'h00, 8'h00);
        int nm;
        build_stream(1'b0, card, 2, 0, 0, 3, 8'h00, 8'h00, -1);
        run_txn(1'b0, 16'h0010, 64'hDEADBEEF_DEADBEEF, ed + 40, -1);
        nm = mosi_errs(1'b0, 16'h0010, '0, 2, 1'b0, done_t);
        n_cmp++; if (done_t !== ed) begin n_bad++; $display("FAIL rd_done_cycle: got %0d want %0d", done_t, ed); end
        n_cmp++; if (cap_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", cap_err); end
        n_cmp++; if (cap_data !== 64'h0123456789ABCDEF) begin
            n_bad++; $display("FAIL rd_data: got %h want 0123456789abcdef", cap_data);
        end
        n_cmp++; if (nm !== 0) begin n_bad++; $display("FAIL rd_mosi: got %0d bad bits want 0", nm); end
        last_out = 64'h0123456789ABCDEF;
    endtask

    task automatic test_r1_error;
        int ed = exp_done(1'b0, 5, 0, 0, 0, 8'h04, 8'h00);
        build_stream(1'b0, 64'h5555AAAA5555AAAA, 5, 0, 0, 0, 8'h04, 8'h00, -1);
        run_txn(1'b0, 16'h0042, '0, ed + 200, -1);
        n_cmp++; if (done_t !== ed) begin n_bad++; $display("FAIL r1err_done_cycle: got %0d want %0d", done_t, ed); end
        n_cmp++; if (cap_err !== 1'b1) begin n_bad++; $display("FAIL r1err_err: got %b want 1", cap_err); end
        n_cmp++; if (cap_data !== last_out) begin n_bad++; $display("FAIL r1err_data_hold: got %h want %h", cap_data, last_out); end
    endtask

    task automatic test_timeout;
        int ed = 48 + TIMEOUT;
        build_stream(1'b0, '0, 1500, 0, 0, 0, 8'h00, 8'h00, -1);
        run_txn(1'b0, 16'h0077, '0, ed + 100, -1);
        n_cmp++; if (done_t !== ed) begin n_bad++; $display("FAIL timeout_done_cycle: got %0d want %0d", done_t, ed); end
        n_cmp++; if (cap_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", cap_err); end
        n_cmp++; if (cap_data !== last_out) begin n_bad++; $display("FAIL timeout_data_hold: got %h want %h", cap_data, last_out); end
    endtask

    task automatic test_dresp_error;
        logic [63:0] d = 64'hFEDCBA9876543210;
        int ed = exp_done(1'b1, 1, 7, 0, 0, 8'h00, 8'h0D);
        int nm;
        build_stream(1'b1, '0, 1, 7, 0, 0, 8'h00, 8'h0D, -1);
        run_txn(1'b1, 16'h0123, d, ed + 40, -1);
        nm = mosi_errs(1'b1, 16'h0123, d, 1, 1'b1, done_t);
        n_cmp++; if (done_t !== ed) begin n_bad++; $display("FAIL dresp_done_cycle: got %0d want %0d", done_t, ed); end
        n_cmp++; if (cap_err !== 1'b1) begin n_bad++; $display("FAIL dresp_err: got %b want 1", cap_err); end
        n_cmp++; if (nm !== 0) begin n_bad++; $display("FAIL dresp_mosi: got %0d bad bits want 0", nm); end
    endtask

    task automatic test_crc_corrupt;
        logic [63:0] card = {$urandom, $urandom};
        int flip = $urandom_range(0, 15);
        int ed = exp_done(1'b0, 0, 0, 0, 1, 8'h00, 8'h00);
        build_stream(1'b0, card, 0, 0, 0, 1, 8'h00, 8'h00, flip);
        run_txn(1'b0, 16'h0022, '0, ed + 40, -1);
        n_cmp++; if (done_t !== ed) begin n_bad++; $display("FAIL crcbad_done_cycle: got %0d want %0d", done_t, ed); end
        n_cmp++; if (cap_err !== CRC_CHK) begin n_bad++; $display("FAIL crcbad_err: got %b want %b", cap_err, CRC_CHK); end
        n_cmp++; if (cap_data !== card) begin n_bad++; $display("FAIL crcbad_data: got %h want %h", cap_data, card); end
        last_out = card;
        mem[16'h0022] = card;
    endtask

    task automatic test_reset_abort;
        logic [63:0] d = 64'hA5A5_0F0F_C3C3_1234;
        int seen = 0;
        int ed;
        build_stream(1'b1, '0, 4, 0, 0, 0, 8'h00, 8'h05, -1);
        run_txn(1'b1, 16'h0055, d, 400, 64 + 4 + 30);
        n_cmp++; if (ab_mosi !== 1'b1) begin n_bad++; $display("FAIL abort_mosi: got %b want 1", ab_mosi); end
        n_cmp++; if (ab_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", ab_ready); end
        n_cmp++; if (ab_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", ab_valid); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen); end
        n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL abort_data_cleared: got %h want 0", out_data); end
        last_out = '0;
        ed = exp_done(1'b1, 2, 1, 3, 0, 8'h00, 8'h05);
        build_stream(1'b1, '0, 2, 1, 3, 0, 8'h00, 8'h05, -1);
        run_txn(1'b1, 16'h0055, d, ed + 40, -1);
        n_cmp++; if (done_t !== ed || cap_err !== 1'b0) begin
            n_bad++; $display("FAIL abort_recover: got done=%0d err=%b want %0d 0", done_t, cap_err, ed);
        end
        if (done_t == ed) mem[16'h0055] = decode_wdata(2);
    endtask

    task automatic test_back_to_back;
        for (int it = 0; it < 20; it++) begin
            bit wr;
            logic [15:0] a;
            logic [63:0] d, card, eo;
            logic [7:0] r1, dr;
            int g, h, b, idle, flt, flip, ed, nm;
            bit ee;
            wr   = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(16'h0010 + $urandom_range(0, 3));
            d    = {$urandom, $urandom};
            g    = $urandom_range(0, 16);
            h    = $urandom_range(0, 8);
            b    = $urandom_range(0, 20);
            idle = $urandom_range(0, 4);
            flt  = $urandom_range(0, 5);
            r1   = (flt == 0) ? 8'($urandom_range(1, 127)) : 8'h00;
            dr   = (wr && flt == 1) ? 8'h0D : 8'h05;
            flip = (!wr && flt == 2) ? $urandom_range(0, 15) : -1;
            card = mem.exists(int'(a)) ? mem[int'(a)] : {$urandom, $urandom};
            ed   = exp_done(wr, g, h, b, idle, r1, dr);
            ee   = (r1 != 8'h00) || (wr && dr != 8'h05) || (!wr && flip >= 0 && CRC_CHK);
            eo   = (!wr && r1 == 8'h00) ? card : last_out;
            build_stream(wr, card, g, h, b, idle, r1, dr, flip);
            run_txn(wr, a, d, ed + 40, -1);
            nm = mosi_errs(wr, a, d, g, wr && r1 == 8'h00, done_t);
            n_cmp++; if (done_t !== ed) begin n_bad++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, done_t, ed); end
            n_cmp++; if (cap_err !== ee) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", it, cap_err, ee); end
            n_cmp++; if (cap_data !== eo) begin n_bad++; $display("FAIL rnd%0d_data: got %h want %h", it, cap_data, eo); end
            n_cmp++; if (nm !== 0) begin n_bad++; $display("FAIL rnd%0d_mosi: got %0d bad bits want 0", it, nm); end
            n_cmp++; if (post_ready !== 1'b1 || post_valid !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d_after_done: got ready=%b valid=%b want 1 0", it, post_ready, post_valid);
            end
            if (!wr && r1 == 8'h00) begin last_out = card; mem[int'(a)] = card; end
            if (wr && r1 == 8'h00 && dr == 8'h05 && done_t == ed) mem[int'(a)] = decode_wdata(g);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_r1_error();
        test_timeout();
        test_dresp_error();
        test_crc_corrupt();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
